// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the issue stage and its register file.
// Holds the datapath/register widths, the opcode and state encodings, the
// instruction field positions and the LI immediate sign-extension helper.
package alu_pkg;

    localparam int unsigned DW    = 16;  // datapath width, matches the ALU
    localparam int unsigned NREGS = 8;   // register-file depth
    localparam int unsigned AW    = 3;   // register-field / RF address width
    localparam int unsigned OPW   = 3;   // opcode width
    localparam int unsigned IMMW  = 6;   // ALU immediate width
    localparam int unsigned LIW   = 10;  // LI immediate width

    // Instruction field LSB positions
    localparam int unsigned OP_LSB     = 13;
    localparam int unsigned RD_LSB     = 10;
    localparam int unsigned RS1_LSB    = 7;
    localparam int unsigned IMMSEL_BIT = 6;
    localparam int unsigned RS2_LSB    = 3;
    localparam int unsigned IMM_LSB    = 0;

    typedef enum logic [OPW-1:0] {
        ALU_ADD  = 3'd0,
        ALU_SUB  = 3'd1,
        ALU_AND  = 3'd2,
        ALU_OR   = 3'd3,
        ALU_XOR  = 3'd4,
        ALU_SLLI = 3'd5,
        ALU_SRLI = 3'd6,
        OP_LI    = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_WB   = 2'd2
    } state_e;

    // Sign-extend the 10-bit LI immediate to the datapath width
    function automatic logic [DW-1:0] li_value(input logic [LIW-1:0] v);
        return {{(DW-LIW){v[LIW-1]}}, v};
    endfunction

endpackage

// File: rtl/alu_issue_if.sv
// alu_issue_if: instruction handshake, ALU operand/result, writeback report
// and debug-read signals of the issue stage.
//   master: instruction source / ALU / debug side
//   slave : alu_issue
interface alu_issue_if;
    import alu_pkg::*;

    logic           InstrValid;
    logic [DW-1:0]  Instr;
    logic           InstrReady;
    logic [DW-1:0]  ALUA;
    logic [DW-1:0]  ALUB;
    logic [OPW-1:0] ALUOpOut;
    logic [DW-1:0]  ALUResult;
    logic           Done;
    logic [DW-1:0]  Result;
    logic [AW-1:0]  DoneRd;
    logic [AW-1:0]  DbgAddr;
    logic [DW-1:0]  DbgData;
    logic [1:0]     Flags;

    modport master (
        output InstrValid, Instr, ALUResult, DbgAddr,
        input  InstrReady, ALUA, ALUB, ALUOpOut, Done, Result, DoneRd, DbgData, Flags
    );

    modport slave (
        input  InstrValid, Instr, ALUResult, DbgAddr,
        output InstrReady, ALUA, ALUB, ALUOpOut, Done, Result, DoneRd, DbgData, Flags
    );

endinterface

// File: rtl/alu_regfile.sv
// alu_regfile: 8x16 register file, two combinational operand reads, one
// combinational debug read, one synchronous write, async active-low reset.
// Entry 0 is cleared by reset and never written, so R0 always reads 0.
//   clk, rst_n      clock / async active-low reset
//   ra1, ra2        operand read addresses -> rd1, rd2
//   dbg_addr        debug read address     -> dbg_data
//   we, wa, wd      write enable / address / data
module alu_regfile
    import alu_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic [AW-1:0] ra1,
    input  logic [AW-1:0] ra2,
    input  logic [AW-1:0] dbg_addr,
    output logic [DW-1:0] rd1,
    output logic [DW-1:0] rd2,
    output logic [DW-1:0] dbg_data,
    input  logic          we,
    input  logic [AW-1:0] wa,
    input  logic [DW-1:0] wd
);

    logic [DW-1:0] regs [NREGS];

    // Storage; writes to R0 are dropped
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(NREGS); i++) begin
                regs[i] <= '0;
            end
        end else if (we && (wa != '0)) begin
            regs[wa] <= wd;
        end
    end

    assign rd1      = regs[ra1];
    assign rd2      = regs[ra2];
    assign dbg_data = regs[dbg_addr];

endmodule

// File: rtl/alu_issue.sv
// alu_issue: issue-and-writeback stage in front of the registered 16-bit ALU.
// IDLE accepts an instruction and latches operands, EXEC presents them to the
// ALU, WB writes the ALU result (or the LI immediate) back to the register file.
//   CLK, RST_N   clock / async active-low reset
//   bus (slave)  InstrValid/Instr/InstrReady handshake, ALUA/ALUB/ALUOpOut to
//                the ALU, ALUResult from it, Done/Result/DoneRd writeback report,
//                DbgAddr/DbgData debug read, Flags {N,Z}
// Optional feature: define ALU_ISSUE_FLAGS_EN to build the {N,Z} flag register;
// otherwise Flags is tied to 0.
module alu_issue
    import alu_pkg::*;
(
    input  logic  CLK,
    input  logic  RST_N,
    alu_issue_if.slave bus
);

    state_e         state_q;
    logic           ready_q;
    logic           done_q;
    logic [DW-1:0]  alu_a_q;
    logic [DW-1:0]  alu_b_q;
    op_e            alu_op_q;
    logic [DW-1:0]  result_q;
    logic [AW-1:0]  done_rd_q;
    logic [AW-1:0]  rd_q;
    logic           is_li_q;

    // Instruction decode
    op_e            op_in;
    logic [AW-1:0]  rd_in;
    logic [AW-1:0]  rs1_in;
    logic [AW-1:0]  rs2_in;
    logic           imm_sel_in;
    logic [IMMW-1:0] imm_in;
    logic [LIW-1:0] li_in;

    assign op_in      = op_e'(bus.Instr[OP_LSB +: OPW]);
    assign rd_in      = bus.Instr[RD_LSB +: AW];
    assign rs1_in     = bus.Instr[RS1_LSB +: AW];
    assign rs2_in     = bus.Instr[RS2_LSB +: AW];
    assign imm_sel_in = bus.Instr[IMMSEL_BIT];
    assign imm_in     = bus.Instr[IMM_LSB +: IMMW];
    assign li_in      = bus.Instr[IMM_LSB +: LIW];

    logic [DW-1:0] rs1_val;
    logic [DW-1:0] rs2_val;
    logic [DW-1:0] wb_val;
    logic          wb_en;

    // LI keeps its immediate in alu_a_q, so no separate holding register is needed
    assign wb_val = is_li_q ? alu_a_q : bus.ALUResult;
    assign wb_en  = (state_q == S_WB);

    alu_regfile u_regfile (
        .clk      (CLK),
        .rst_n    (RST_N),
        .ra1      (rs1_in),
        .ra2      (rs2_in),
        .dbg_addr (bus.DbgAddr),
        .rd1      (rs1_val),
        .rd2      (rs2_val),
        .dbg_data (bus.DbgData),
        .we       (wb_en),
        .wa       (rd_q),
        .wd       (wb_val)
    );

    // Sequencer: IDLE -> EXEC -> WB -> IDLE, all outputs registered
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q   <= S_IDLE;
            ready_q   <= 1'b1;
            done_q    <= 1'b0;
            alu_a_q   <= '0;
            alu_b_q   <= '0;
            alu_op_q  <= ALU_ADD;
            result_q  <= '0;
            done_rd_q <= '0;
            rd_q      <= '0;
            is_li_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (bus.InstrValid && ready_q) begin
                        state_q <= S_EXEC;
                        ready_q <= 1'b0;
                        rd_q    <= rd_in;
                        is_li_q <= (op_in == OP_LI);
                        if (op_in == OP_LI) begin
                            alu_a_q  <= li_value(li_in);
                            alu_b_q  <= '0;
                            alu_op_q <= ALU_ADD;
                        end else begin
                            alu_a_q  <= rs1_val;
                            alu_b_q  <= imm_sel_in ? DW'(imm_in) : rs2_val;
                            alu_op_q <= op_in;
                        end
                    end
                end
                S_EXEC: begin
                    state_q <= S_WB;
                end
                S_WB: begin
                    state_q   <= S_IDLE;
                    ready_q   <= 1'b1;
                    done_q    <= 1'b1;
                    result_q  <= wb_val;
                    done_rd_q <= rd_q;
                end
                default: begin
                    state_q <= S_IDLE;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

`ifdef ALU_ISSUE_FLAGS_EN
    logic [1:0] flags_q;

    // {N,Z} of every written-back value, including discarded R0 writes
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            flags_q <= 2'b00;
        end else if (wb_en) begin
            flags_q <= {wb_val[DW-1], (wb_val == '0)};
        end
    end

    assign bus.Flags = flags_q;
`else
    assign bus.Flags = 2'b00;
`endif

    assign bus.InstrReady = ready_q;
    assign bus.Done       = done_q;
    assign bus.ALUA       = alu_a_q;
    assign bus.ALUB       = alu_b_q;
    assign bus.ALUOpOut   = alu_op_q;
    assign bus.Result     = result_q;
    assign bus.DoneRd     = done_rd_q;

endmodule

// File: tb/tb_alu_issue.sv
// tb_alu_issue: self-checking bench for alu_issue with a behavioural ALU and
// a register-file reference model.
module tb_alu_issue;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    alu_issue_if bus();

    alu_issue u_dut (
        .CLK   (clk),
        .RST_N (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [15:0] ref_rf [8];
    logic [1:0]  ref_flags;

    function automatic logic [15:0] alu_f(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
        case (op)
            3'd0:    return a + b;
            3'd1:    return a - b;
            3'd2:    return a & b;
            3'd3:    return a | b;
            3'd4:    return a ^ b;
            3'd5:    return a << b;
            3'd6:    return a >> b;
            default: return 16'h0000;
        endcase
    endfunction

    // Registered ALU in front of the issue stage
    always @(posedge clk) bus.ALUResult <= alu_f(bus.ALUOpOut, bus.ALUA, bus.ALUB);

    function automatic logic [15:0] model_exec(input logic [15:0] ins);
        logic [15:0] a;
        logic [15:0] b;
        if (ins[15:13] == 3'd7) return {{6{ins[9]}}, ins[9:0]};
        a = ref_rf[ins[9:7]];
        b = ins[6] ? {10'd0, ins[5:0]} : ref_rf[ins[5:3]];
        return alu_f(ins[15:13], a, b);
    endfunction

    function automatic logic [15:0] enc_r(input logic [2:0] op, input logic [2:0] rd, input logic [2:0] rs1, input logic [2:0] rs2);
        return {op, rd, rs1, 1'b0, rs2, 3'b000};
    endfunction

    function automatic logic [15:0] enc_i(input logic [2:0] op, input logic [2:0] rd, input logic [2:0] rs1, input logic [5:0] imm);
        return {op, rd, rs1, 1'b1, imm};
    endfunction

    function automatic logic [15:0] enc_li(input logic [2:0] rd, input logic [9:0] imm);
        return {3'd7, rd, imm};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_wb(input logic [2:0] rd, input logic [15:0] val);
        if (rd != 3'd0) ref_rf[rd] = val;
`ifdef ALU_ISSUE_FLAGS_EN
        ref_flags = {val[15], (val == 16'h0000)};
`endif
    endtask

    // Issue one instruction from IDLE and follow it to writeback
    task automatic run_instr(input logic [15:0] ins, input logic [15:0] exp_res, input logic [2:0] exp_rd);
        logic [15:0] ea;
        logic [15:0] eb;
        logic [15:0] old;
        logic [2:0]  eop;
        int n;
        ea  = ref_rf[ins[9:7]];
        eb  = ins[6] ? {10'd0, ins[5:0]} : ref_rf[ins[5:3]];
        eop = (ins[15:13] == 3'd7) ? 3'd0 : ins[15:13];
        old = ref_rf[exp_rd];
        @(negedge clk);
        chk("ready_idle", 32'(bus.InstrReady), 1);
        bus.InstrValid = 1'b1;
        bus.Instr      = ins;
        @(posedge clk);
        #1;
        bus.InstrValid = 1'b0;
        bus.Instr      = 16'($urandom);
        @(negedge clk);
        chk("ready_exec", 32'(bus.InstrReady), 0);
        chk("op_exec", 32'(bus.ALUOpOut), 32'(eop));
        if (ins[15:13] != 3'd7) begin
            chk("a_exec", 32'(bus.ALUA), 32'(ea));
            chk("b_exec", 32'(bus.ALUB), 32'(eb));
        end
        @(negedge clk);
        bus.DbgAddr = exp_rd;
        #1;
        chk("dbg_old", 32'(bus.DbgData), 32'(old));
        chk("done_early", 32'(bus.Done), 0);
        n = 0;
        for (int c = 3; c <= 8; c++) begin
            @(negedge clk);
            if (bus.Done) begin
                n = c;
                break;
            end
        end
        chk("done_latency", 32'(n), 3);
        model_wb(exp_rd, exp_res);
        #1;
        chk("result", 32'(bus.Result), 32'(exp_res));
        chk("done_rd", 32'(bus.DoneRd), 32'(exp_rd));
        chk("dbg_new", 32'(bus.DbgData), 32'(ref_rf[exp_rd]));
        chk("flags", 32'(bus.Flags), 32'(ref_flags));
        chk("ready_done", 32'(bus.InstrReady), 1);
        @(negedge clk);
        chk("done_pulse", 32'(bus.Done), 0);
    endtask

    typedef struct {
        logic [15:0] ins;
        logic [15:0] res;
        logic [2:0]  rd;
    } vec_t;

    vec_t tbl [8];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] i1, i2, e1, e2, ins, ex;
        logic [6:0]  exp_rdy, exp_dn;

        tbl[0] = '{enc_li(3'd1, 10'd2),             16'h0002, 3'd1};
        tbl[1] = '{enc_li(3'd2, 10'd1),             16'h0001, 3'd2};
        tbl[2] = '{enc_r(3'd0, 3'd3, 3'd1, 3'd2),   16'h0003, 3'd3};
        tbl[3] = '{enc_r(3'd1, 3'd5, 3'd2, 3'd1),   16'hFFFF, 3'd5};
        tbl[4] = '{enc_r(3'd1, 3'd4, 3'd1, 3'd1),   16'h0000, 3'd4};
        tbl[5] = '{enc_i(3'd5, 3'd6, 3'd1, 6'd1),   16'h0004, 3'd6};
        tbl[6] = '{enc_r(3'd0, 3'd0, 3'd1, 3'd2),   16'h0003, 3'd0};
        tbl[7] = '{enc_li(3'd7, 10'h200),           16'hFE00, 3'd7};

        for (int i = 0; i < 8; i++) ref_rf[i] = 16'h0000;
        ref_flags      = 2'b00;
        bus.InstrValid = 1'b0;
        bus.Instr      = 16'h0000;
        bus.DbgAddr    = 3'd0;

        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_ready", 32'(bus.InstrReady), 1);
        chk("rst_done", 32'(bus.Done), 0);
        chk("rst_a", 32'(bus.ALUA), 0);
        chk("rst_b", 32'(bus.ALUB), 0);
        chk("rst_op", 32'(bus.ALUOpOut), 0);
        chk("rst_result", 32'(bus.Result), 0);
        chk("rst_donerd", 32'(bus.DoneRd), 0);
        chk("rst_flags", 32'(bus.Flags), 0);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            bus.DbgAddr = 3'(i);
            #1;
            chk("rst_rf", 32'(bus.DbgData), 0);
        end

        // Directed table
        for (int i = 0; i < 8; i++) run_instr(tbl[i].ins, tbl[i].res, tbl[i].rd);

        // Back-to-back issue with InstrValid held; second depends on first
        i1 = enc_r(3'd0, 3'd7, 3'd1, 3'd2);
        e1 = model_exec(i1);
        @(negedge clk);
        bus.InstrValid = 1'b1;
        bus.Instr      = i1;
        @(posedge clk);
        exp_rdy = 7'b1100100;  // bit c-1 = expected InstrReady at negedge c
        exp_dn  = 7'b0100100;
        for (int c = 1; c <= 7; c++) begin
            @(negedge clk);
            chk("b2b_ready", 32'(bus.InstrReady), 32'(exp_rdy[c-1]));
            chk("b2b_done", 32'(bus.Done), 32'(exp_dn[c-1]));
            if (c == 1) begin
                bus.Instr = enc_i(3'd4, 3'd1, 3'd7, 6'h15);
            end
            if (c == 3) begin
                model_wb(3'd7, e1);
                chk("b2b_res1", 32'(bus.Result), 32'(e1));
                chk("b2b_rd1", 32'(bus.DoneRd), 7);
                chk("b2b_flags1", 32'(bus.Flags), 32'(ref_flags));
                i2 = bus.Instr;
                e2 = model_exec(i2);
            end
            if (c == 4) bus.InstrValid = 1'b0;
            if (c == 6) begin
                model_wb(3'd1, e2);
                chk("b2b_res2", 32'(bus.Result), 32'(e2));
                chk("b2b_rd2", 32'(bus.DoneRd), 1);
                chk("b2b_flags2", 32'(bus.Flags), 32'(ref_flags));
            end
        end

        // Reset during EXEC aborts the instruction
        @(negedge clk);
        bus.InstrValid = 1'b1;
        bus.Instr      = enc_r(3'd0, 3'd3, 3'd1, 3'd2);
        @(posedge clk);
        #1 bus.InstrValid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_ready", 32'(bus.InstrReady), 1);
        chk("abort_done", 32'(bus.Done), 0);
        chk("abort_a", 32'(bus.ALUA), 0);
        chk("abort_b", 32'(bus.ALUB), 0);
        chk("abort_result", 32'(bus.Result), 0);
        chk("abort_flags", 32'(bus.Flags), 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) ref_rf[i] = 16'h0000;
        ref_flags = 2'b00;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("abort_nodone", 32'(bus.Done), 0);
        end
        bus.DbgAddr = 3'd3;
        #1;
        chk("abort_r3", 32'(bus.DbgData), 0);
        run_instr(enc_li(3'd3, 10'h3FF), 16'hFFFF, 3'd3);

        // Randomized instructions against the reference model
        for (int k = 0; k < 40; k++) begin
            ins = 16'($urandom);
            ex  = model_exec(ins);
            run_instr(ins, ex, ins[12:10]);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_issue.md
# alu_issue

Issue-and-writeback stage directly upstream of the registered 16-bit `alu`. It accepts 16-bit instructions over a valid/ready handshake and reads operands from an internal 8×16 register file. It drives `A`/`B`/`ALUOp` into the ALU, captures `ALUOut` one clock later, and writes the result back to the destination register. The block is a 3-state sequencer with a throughput of one instruction per 3 cycles.

## Interface
Parameters:
- `NREGS`, 8: register-file depth; fixed at 8 because register fields are 3 bits.
- `DW`, 16: datapath width; must match the ALU.

Ports:
- `CLK`  in  1  rising-edge clock, shared with `alu`.
- `RST_N`  in  1  reset, asynchronous assert, active-low.
- `InstrValid`  in  1  instruction present.
- `Instr`  in  16  instruction word.
- `InstrReady`  out  1  block can accept an instruction.
- `ALUA`  out  16  ALU operand A.
- `ALUB`  out  16  ALU operand B.
- `ALUOpOut`  out  3  ALU opcode.
- `ALUResult`  in  16  ALU `ALUOut`, registered inside the ALU.
- `Done`  out  1  one-cycle pulse: writeback completed.
- `Result`  out  16  value written at the last writeback.
- `DoneRd`  out  3  destination register of the last writeback.
- `DbgAddr`  in  3  debug read address.
- `DbgData`  out  16  combinational read of `RF[DbgAddr]`.
- `Flags`  out  2  {N,Z}; see Configuration.

## Operation
- Instruction format:
  - `[15:13]` Op: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLLI, 6 SRLI, 7 LI.
  - `[12:10]` Rd.
  - `[9:7]` Rs1.
  - `[6]` ImmSel.
  - If ImmSel=1: `[5:0]` Imm6, zero-extended to B.
  - If ImmSel=0: `[5:3]` Rs2; `[2:0]` ignored.
- LI writes `Instr[9:0]` sign-extended into Rd. The ALU result is ignored for LI, but LI follows the same state sequence so latency stays uniform.
- R0 reads as 0. Writes to R0 are discarded, but `Done`, `Result` and `DoneRd` still update.
- State machine:
  - IDLE: `InstrReady`=1. Handshake (`InstrValid & InstrReady`) at an edge: latch Op, Rd and operands (read from RF at that edge) → EXEC.
  - EXEC: `ALUA`, `ALUB`, `ALUOpOut` hold the latched values. At the next edge → WB.
  - WB: `ALUResult` is valid. At the next edge: write RF[Rd], set `Done`=1, load `Result`/`DoneRd` → IDLE.
- `ALUA`, `ALUB`, `ALUOpOut` are registers and hold their last values while in IDLE.
- For LI, `ALUOpOut` = 0 (ADD) and its result is discarded.

## Timing
- Reset values:
  - State IDLE; all RF entries 0.
  - `InstrReady`=1, `Done`=0.
  - `ALUA`=`ALUB`=`Result`=0, `ALUOpOut`=0, `DoneRd`=0, `Flags`=0.
- Latency: handshake edge E0 → `Done` high in the cycle after E2 (edge E0+2), for exactly one cycle.
- `InstrReady` is low from E0 to E2 and high again in the same cycle as `Done`.
- Back-to-back issue: the next accept can occur at E0+3.
- RAW hazards cannot occur: writeback completes before the next operand read, so no bypass is required.
- Debug read of a register being written in the same cycle returns the old value.
- `Instr` is sampled only at the handshake edge; changes while `InstrReady`=0 are ignored.
- Reset asserted mid-instruction aborts it immediately: no writeback, no `Done`, all outputs return to reset values.

## Configuration
- `ALU_ISSUE_FLAGS_EN` defined:
  - Each writeback also updates `Flags`: Z = (value == 0), N = value[15].
  - LI updates flags too.
  - Writes to R0 update flags from the discarded value.
- Undefined: `Flags` is tied to 2'b00 and no flag register is built.

## Structure
- Shared package `alu_pkg`:
  - Op encodings (ALU_ADD..ALU_SRLI, OP_LI).
  - Instruction field bit positions.
  - State enum (S_IDLE, S_EXEC, S_WB).
  - `DW`.
- Sub-module `alu_regfile`: 8×16, two combinational read ports plus the debug read port, one synchronous write port, async reset, R0 hardwired to 0.
- Sequencer and decode stay in `alu_issue`.

## Test plan
- Reset, then LI R1,#2; LI R2,#1; ADD R3,R1,R2 → `Done` with `Result`=3, `DoneRd`=3; `DbgData`@3 = 3; `ALUOpOut` was 0 during EXEC.
- SUB R5,R2,R1 → `Result`=16'hFFFF. With the flags macro, `Flags`={1,0}. SUB R4,R1,R1 → `Result`=0, `Flags`={0,1}.
- SLLI R6,R1,ImmSel=1,Imm6=1 → `ALUB`=1 during EXEC; `Result`=4, `DoneRd`=6.
- ADD R0,R1,R2 → `Done` pulses with `Result`=3, `DoneRd`=0; `DbgData`@0 stays 0.
- `InstrValid` held high with two queued instructions → accepts exactly 3 cycles apart; `InstrReady` low for 2 cycles after each accept; one `Done` per instruction.
- Assert `RST_N`=0 during EXEC of ADD R3 → no `Done`; R3=0; `InstrReady`=1 immediately; the next instruction completes normally.
